// File: rtl/id_ex_decode.sv
// id_ex_decode: decodes a MIPS-subset instruction in the decode stage and
// registers the resulting control strobes, ALU select and operand fields into
// the ID/EX pipeline register. Supports stall (hold), flush (bubble) and
// synchronous reset (bubble).
module id_ex_decode #(
  parameter bit IMM_LOGIC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic [2:0]  alu_select_e,
  output logic        regwrite_e,
  output logic        memtoreg_e,
  output logic        memwrite_e,
  output logic        branch_e,
  output logic        alusrc_e,
  output logic        regdst_e,
  output logic        jump_e,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic [4:0]  rd_e,
  output logic [31:0] imm_e,
  output logic        valid_e,
  output logic        illegal_e
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU select encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Contents of the ID/EX register
  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [2:0]  alu_sel;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        alusrc;
    logic        regdst;
    logic        jump;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } ex_reg_t;

  ex_reg_t   dec_s;
  ex_reg_t   bubble_s;
  ex_reg_t   ex_d;
  ex_reg_t   ex_q;
  logic [5:0] opcode_s;
  logic [5:0] funct_s;

  assign opcode_s = instr_d[31:26];
  assign funct_s  = instr_d[5:0];

  // Bubble pattern: nothing valid, every strobe low, ALU select parked on ADD
  always_comb begin
    bubble_s         = '0;
    bubble_s.alu_sel = ALU_ADD;
  end

  // Combinational decode of the instruction presented in the decode stage
  always_comb begin
    dec_s         = '0;
    dec_s.valid   = 1'b1;
    dec_s.alu_sel = ALU_ADD;
    dec_s.rs      = instr_d[25:21];
    dec_s.rt      = instr_d[20:16];
    dec_s.rd      = instr_d[15:11];
    dec_s.imm     = {{16{instr_d[15]}}, instr_d[15:0]};

    case (opcode_s)
      OP_RTYPE: begin
        dec_s.regwrite = 1'b1;
        dec_s.regdst   = 1'b1;
        case (funct_s)
          FN_ADD:  dec_s.alu_sel = ALU_ADD;
          FN_SUB:  dec_s.alu_sel = ALU_SUB;
          FN_AND:  dec_s.alu_sel = ALU_AND;
          FN_OR:   dec_s.alu_sel = ALU_OR;
          FN_SLT:  dec_s.alu_sel = ALU_SLT;
          default: dec_s.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        dec_s.regwrite = 1'b1;
        dec_s.memtoreg = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.alu_sel  = ALU_ADD;
      end
      OP_SW: begin
        dec_s.memwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.alu_sel  = ALU_ADD;
      end
      OP_BEQ: begin
        dec_s.branch  = 1'b1;
        dec_s.alu_sel = ALU_SUB;
      end
      OP_ADDI: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.alu_sel  = ALU_ADD;
      end
      OP_J: begin
        dec_s.jump    = 1'b1;
        dec_s.alu_sel = ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (IMM_LOGIC) begin
          dec_s.regwrite = 1'b1;
          dec_s.alusrc   = 1'b1;
          case (opcode_s)
            OP_ANDI: dec_s.alu_sel = ALU_AND;
            OP_ORI:  dec_s.alu_sel = ALU_OR;
            default: dec_s.alu_sel = ALU_SLT;
          endcase
        end else begin
          dec_s.illegal = 1'b1;
        end
      end
      default: dec_s.illegal = 1'b1;
    endcase

    // An illegal instruction still carries its fields but drives no strobes
    if (dec_s.illegal) begin
      dec_s.alu_sel  = ALU_ADD;
      dec_s.regwrite = 1'b0;
      dec_s.memtoreg = 1'b0;
      dec_s.memwrite = 1'b0;
      dec_s.branch   = 1'b0;
      dec_s.alusrc   = 1'b0;
      dec_s.regdst   = 1'b0;
      dec_s.jump     = 1'b0;
    end else begin
      dec_s.illegal  = 1'b0;
    end
  end

  // Next register value: flush beats stall, stall beats a new load
  always_comb begin
    ex_d = bubble_s;
    if (flush_e) begin
      ex_d = bubble_s;
    end else if (stall_e) begin
      ex_d = ex_q;
    end else if (valid_d) begin
      ex_d = dec_s;
    end else begin
      ex_d = bubble_s;
    end
  end

  // ID/EX pipeline register with synchronous reset to a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= bubble_s;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign valid_e      = ex_q.valid;
  assign illegal_e    = ex_q.illegal;
  assign alu_select_e = ex_q.alu_sel;
  assign regwrite_e   = ex_q.regwrite;
  assign memtoreg_e   = ex_q.memtoreg;
  assign memwrite_e   = ex_q.memwrite;
  assign branch_e     = ex_q.branch;
  assign alusrc_e     = ex_q.alusrc;
  assign regdst_e     = ex_q.regdst;
  assign jump_e       = ex_q.jump;
  assign rs_e         = ex_q.rs;
  assign rt_e         = ex_q.rt;
  assign rd_e         = ex_q.rd;
  assign imm_e        = ex_q.imm;

endmodule

// File: tb/tb_id_ex_decode.sv
// tb_id_ex_decode: directed-vector bench for id_ex_decode. Two instances
// (IMM_LOGIC=1 and IMM_LOGIC=0) share the same stimulus; a behavioural model
// predicts both register contents and is compared every cycle after reset.
module tb_id_ex_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'h0;
  logic        valid_d = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;

  logic [2:0]  sel1, sel0;
  logic        rw1, mtr1, mw1, br1, as1, rdst1, j1, v1, ill1;
  logic        rw0, mtr0, mw0, br0, as0, rdst0, j0, v0, ill0;
  logic [4:0]  rs1, rt1, rd1, rs0, rt0, rd0;
  logic [31:0] imm1, imm0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_decode #(.IMM_LOGIC(1'b1)) dut1 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .alu_select_e(sel1),
    .regwrite_e(rw1), .memtoreg_e(mtr1), .memwrite_e(mw1), .branch_e(br1),
    .alusrc_e(as1), .regdst_e(rdst1), .jump_e(j1), .rs_e(rs1), .rt_e(rt1),
    .rd_e(rd1), .imm_e(imm1), .valid_e(v1), .illegal_e(ill1)
  );

  id_ex_decode #(.IMM_LOGIC(1'b0)) dut0 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .alu_select_e(sel0),
    .regwrite_e(rw0), .memtoreg_e(mtr0), .memwrite_e(mw0), .branch_e(br0),
    .alusrc_e(as0), .regdst_e(rdst0), .jump_e(j0), .rs_e(rs0), .rt_e(rt0),
    .rd_e(rd0), .imm_e(imm0), .valid_e(v0), .illegal_e(ill0)
  );

  // Packed view of all outputs: {valid, illegal, sel, rw,mtr,mw,br,as,rdst,j, rs, rt, rd, imm}
  logic [58:0] act1, act0;
  assign act1 = {v1, ill1, sel1, rw1, mtr1, mw1, br1, as1, rdst1, j1, rs1, rt1, rd1, imm1};
  assign act0 = {v0, ill0, sel0, rw0, mtr0, mw0, br0, as0, rdst0, j0, rs0, rt0, rd0, imm0};

  localparam logic [58:0] BUBBLE = {2'b00, 3'b010, 7'b0000000, 15'd0, 32'd0};

  // Expected register contents for one instruction, straight from the ISA table
  function automatic logic [58:0] golden(input logic [31:0] ins, input bit imm_logic);
    logic [2:0] sel;
    logic [6:0] fl;
    logic       ill;
    sel = 3'b010;
    fl  = 7'b0000000;
    ill = 1'b0;
    case (ins[31:26])
      6'h00: begin
        fl = 7'b1000010;
        case (ins[5:0])
          6'h20:   sel = 3'b010;
          6'h22:   sel = 3'b110;
          6'h24:   sel = 3'b000;
          6'h25:   sel = 3'b001;
          6'h2a:   sel = 3'b111;
          default: ill = 1'b1;
        endcase
      end
      6'h23:   fl = 7'b1100100;
      6'h2b:   fl = 7'b0010100;
      6'h04:   begin fl = 7'b0001000; sel = 3'b110; end
      6'h08:   fl = 7'b1000100;
      6'h02:   fl = 7'b0000001;
      6'h0c:   begin fl = 7'b1000100; sel = 3'b000; ill = !imm_logic; end
      6'h0d:   begin fl = 7'b1000100; sel = 3'b001; ill = !imm_logic; end
      6'h0a:   begin fl = 7'b1000100; sel = 3'b111; ill = !imm_logic; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      fl  = 7'b0000000;
      sel = 3'b010;
    end
    return {1'b1, ill, sel, fl, ins[25:21], ins[20:16], ins[15:11],
            {{16{ins[15]}}, ins[15:0]}};
  endfunction

  logic [58:0] exp1, exp0;
  bit          model_known = 1'b0;

  // Reference pipeline register: reset > flush > stall > load
  always @(posedge clk) begin
    if (reset) begin
      exp1 <= BUBBLE; exp0 <= BUBBLE; model_known <= 1'b1;
    end else if (flush_e) begin
      exp1 <= BUBBLE; exp0 <= BUBBLE;
    end else if (stall_e) begin
      exp1 <= exp1; exp0 <= exp0;
    end else if (valid_d) begin
      exp1 <= golden(instr_d, 1'b1); exp0 <= golden(instr_d, 1'b0);
    end else begin
      exp1 <= BUBBLE; exp0 <= BUBBLE;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_known) begin
      n_checks++;
      if (act1 !== exp1) begin
        n_fail++;
        $display("FAIL model_imm1 t=%0t actual=%h expected=%h", $time, act1, exp1);
      end
      n_checks++;
      if (act0 !== exp0) begin
        n_fail++;
        $display("FAIL model_imm0 t=%0t actual=%h expected=%h", $time, act0, exp0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land just after the edge that consumes them
  task automatic step(input logic [31:0] ins, input logic v, input logic st,
                      input logic fl, input logic rst);
    instr_d = ins; valid_d = v; stall_e = st; flush_e = fl; reset = rst;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD  = 32'h012A4020; // add  $8,$9,$10
  localparam logic [31:0] LW   = 32'h8D28FFFC; // lw   $8,-4($9)
  localparam logic [31:0] BEQ  = 32'h11090003; // beq  $8,$9,3
  localparam logic [31:0] SW   = 32'hAD280004; // sw   $8,4($9)
  localparam logic [31:0] BADF = 32'h0128402B; // R-type funct 101011
  localparam logic [31:0] ORI  = 32'h35280001; // ori  $8,$9,1
  localparam logic [31:0] SLT  = 32'h012A402A; // slt  $8,$9,$10
  localparam logic [31:0] SLTI = 32'h2928FFFF; // slti $8,$9,-1

  logic [31:0] mix [10];

  initial begin
    mix = '{ADD, LW, 32'h01095022, 32'h012A4024, 32'h012A4025, 32'h08000010,
            32'h21280005, 32'h3128F000, 32'hFC000000, BEQ};

    step(32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_valid", {31'd0, v1}, 32'd0);
    chk("reset_sel", {29'd0, sel1}, 32'd2);
    chk("reset_imm", imm1, 32'd0);

    step(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("add_sel", {29'd0, sel1}, 32'd2);
    chk("add_regwrite", {31'd0, rw1}, 32'd1);
    chk("add_regdst", {31'd0, rdst1}, 32'd1);
    chk("add_rs", {27'd0, rs1}, 32'd9);
    chk("add_rt", {27'd0, rt1}, 32'd10);
    chk("add_rd", {27'd0, rd1}, 32'd8);
    chk("add_valid", {31'd0, v1}, 32'd1);

    step(LW, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lw_sel", {29'd0, sel1}, 32'd2);
    chk("lw_memtoreg", {31'd0, mtr1}, 32'd1);
    chk("lw_alusrc", {31'd0, as1}, 32'd1);
    chk("lw_regwrite", {31'd0, rw1}, 32'd1);
    chk("lw_imm", imm1, 32'hFFFFFFFC);

    step(BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq_branch", {31'd0, br1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(ADD, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stall_branch", {31'd0, br1}, 32'd1);
      chk("stall_sel", {29'd0, sel1}, 32'd6);
    end
    step(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_stall_sel", {29'd0, sel1}, 32'd2);
    chk("after_stall_branch", {31'd0, br1}, 32'd0);
    chk("after_stall_rd", {27'd0, rd1}, 32'd8);

    step(SW, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, v1}, 32'd0);
    chk("flush_memwrite", {31'd0, mw1}, 32'd0);
    chk("flush_sel", {29'd0, sel1}, 32'd2);

    step(BADF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("badfunct_illegal", {31'd0, ill1}, 32'd1);
    chk("badfunct_valid", {31'd0, v1}, 32'd1);
    chk("badfunct_strobes", {25'd0, rw1, mtr1, mw1, br1, as1, rdst1, j1}, 32'd0);

    step(ORI, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ori0_illegal", {31'd0, ill0}, 32'd1);
    chk("ori0_valid", {31'd0, v0}, 32'd1);
    chk("ori0_strobes", {25'd0, rw0, mtr0, mw0, br0, as0, rdst0, j0}, 32'd0);
    chk("ori0_imm", imm0, 32'd1);
    chk("ori1_sel", {29'd0, sel1}, 32'd1);
    chk("ori1_illegal", {31'd0, ill1}, 32'd0);

    step(ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("novalid_valid", {31'd0, v1}, 32'd0);
    chk("novalid_rs", {27'd0, rs1}, 32'd0);

    step(SLT, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("slt_sel", {29'd0, sel1}, 32'd7);
    step(ADD, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_stall_valid", {31'd0, v1}, 32'd0);
    chk("reset_stall_sel", {29'd0, sel1}, 32'd2);
    chk("reset_stall_rd", {27'd0, rd1}, 32'd0);
    step(ADD, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_reset_stall_valid", {31'd0, v1}, 32'd0);
    step(SLTI, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("slti_sel", {29'd0, sel1}, 32'd7);
    chk("slti_alusrc", {31'd0, as1}, 32'd1);
    chk("slti_imm", imm1, 32'hFFFFFFFF);
    chk("slti0_illegal", {31'd0, ill0}, 32'd1);

    // Back-to-back traffic with interleaved stalls, flushes and idle slots
    for (int i = 0; i < 60; i++) begin
      step(mix[i % 10], (i % 9) != 8, (i % 5) == 3, (i % 7) == 6, 1'b0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
